// File: rtl/stream_mux2to1.sv
// stream_mux2to1: registered 2-to-1 valid/ready stream merge with arbitration.
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   D0, V0, R0      channel 0 data / valid / ready
//   D1, V1, R1      channel 1 data / valid / ready
//   Y, YV, S        registered merged data / valid / source channel
//   YR              downstream ready
module stream_mux2to1 #(
    parameter int W          = 8,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] D0,
    input  logic         V0,
    output logic         R0,
    input  logic [W-1:0] D1,
    input  logic         V1,
    output logic         R1,
    output logic [W-1:0] Y,
    output logic         YV,
    output logic         S,
    input  logic         YR
);
    logic [W-1:0] r_y;
    logic         r_yv;
    logic         r_s;
    logic         r_last;
    logic         w_space;
    logic         w_g0;
    logic         w_g1;
    logic         w_acc0;
    logic         w_acc1;

    // Under contention channel 0 wins when priority is fixed or channel 1 went last.
    always_comb begin
        w_space = ~r_yv | YR;
        w_g0    = V0 & (~V1 | FIXED_PRIO | r_last);
        w_g1    = V1 & ~w_g0;
        // rst_n gating keeps both readies low for the whole reset window.
        R0      = rst_n & w_space & w_g0;
        R1      = rst_n & w_space & w_g1;
        w_acc0  = R0 & V0;
        w_acc1  = R1 & V1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y    <= '0;
            r_s    <= 1'b0;
            r_yv   <= 1'b0;
            r_last <= 1'b1;
        end else if (w_acc0 | w_acc1) begin
            r_y    <= w_acc1 ? D1 : D0;
            r_s    <= w_acc1;
            r_yv   <= 1'b1;
            r_last <= w_acc1;
        end else if (YR) begin
            r_yv   <= 1'b0;
        end
    end

    assign Y  = r_y;
    assign YV = r_yv;
    assign S  = r_s;
endmodule

// File: tb/tb_stream_mux2to1.sv
// tb_stream_mux2to1: directed and random checks of round-robin and fixed-priority merges.
module tb_stream_mux2to1;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] D0, D1;
    logic       V0, V1, YR;
    logic [1:0] r0, r1, yv, s;
    logic [7:0] y [2];

    int nvec  = 0;
    int nfail = 0;

    logic       m_full [2];
    logic [7:0] m_y    [2];
    logic       m_s    [2];
    logic       m_last [2];

    always #5 clk = ~clk;

    stream_mux2to1 #(.W(8), .FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .D0(D0), .V0(V0), .R0(r0[0]),
        .D1(D1), .V1(V1), .R1(r1[0]), .Y(y[0]), .YV(yv[0]), .S(s[0]), .YR(YR)
    );

    stream_mux2to1 #(.W(8), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .D0(D0), .V0(V0), .R0(r0[1]),
        .D1(D1), .V1(V1), .R1(r1[1]), .Y(y[1]), .YV(yv[1]), .S(s[1]), .YR(YR)
    );

    task automatic chk(input string tag, input int m, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s[m%0d] observed=%h expected=%h", tag, m, obs, exp);
        end
    endtask

    // Returns {some channel granted, granted channel}; model 1 is fixed priority.
    function automatic logic [1:0] grant(input int m);
        if (V0 && V1) return {1'b1, (m == 1) ? 1'b0 : ~m_last[m]};
        if (V0) return 2'b10;
        if (V1) return 2'b11;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_full[m] = 1'b0;
            m_y[m]    = 8'h00;
            m_s[m]    = 1'b0;
            m_last[m] = 1'b1;
        end
    endtask

    task automatic chk_out(input int m);
        chk("YV", m, {7'b0, yv[m]}, {7'b0, m_full[m]});
        chk("Y", m, y[m], m_y[m]);
        chk("S", m, {7'b0, s[m]}, {7'b0, m_s[m]});
    endtask

    // Inputs are already applied (posedge+1); check mid-cycle, then advance the model at the edge.
    task automatic step();
        logic [1:0] g [2];
        logic       sp [2];
        #4;
        for (int m = 0; m < 2; m++) begin
            g[m]  = grant(m);
            sp[m] = !m_full[m] || YR;
            chk("R0", m, {7'b0, r0[m]}, {7'b0, sp[m] && g[m][1] && !g[m][0]});
            chk("R1", m, {7'b0, r1[m]}, {7'b0, sp[m] && g[m][1] && g[m][0]});
            chk_out(m);
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (sp[m] && g[m][1]) begin
                m_y[m]    = g[m][0] ? D1 : D0;
                m_s[m]    = g[m][0];
                m_full[m] = 1'b1;
                m_last[m] = g[m][0];
            end else if (YR) begin
                m_full[m] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic set_in(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1, input logic yr);
        V0 = v0; D0 = d0; V1 = v1; D1 = d1; YR = yr;
    endtask

    // Asserts reset asynchronously at the current time and checks the outputs clear at once.
    task automatic do_reset();
        set_in(1'b1, 8'hFF, 1'b1, 8'hEE, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("rstR0", m, {7'b0, r0[m]}, 8'h00);
            chk("rstR1", m, {7'b0, r1[m]}, 8'h00);
            chk_out(m);
        end
        set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(posedge clk);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1 do_reset();

        set_in(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
        repeat (4) step();
        step();

        do_reset();
        set_in(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        repeat (4) step();
        set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step();

        do_reset();
        set_in(1'b0, 8'h00, 1'b1, 8'h3C, 1'b1);
        step();
        set_in(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0);
        repeat (3) step();
        YR = 1'b1;
        step();
        set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step();

        do_reset();
        set_in(1'b1, 8'h7E, 1'b0, 8'h00, 1'b1);
        step();
        set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        repeat (2) step();
        set_in(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        repeat (2) step();

        do_reset();
        for (int i = 0; i < 300; i++) begin
            set_in(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
            step();
        end

        set_in(1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
        step();
        set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        step();
        #1 do_reset();
        set_in(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        repeat (3) step();
        set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/stream_mux2to1.md
Name: stream_mux2to1

Overview:
- Registered 2-to-1 stream multiplexer with arbitration. It is the merge-side counterpart of the 1-to-2 demux.
- Two independent valid/ready input channels (D0, D1) are merged onto one output channel (Y).
- Y is tagged with a select bit S that names the source channel. A downstream demux1to2 driven by S recreates the original split.
- Sits between two producers and one shared consumer. Provides one output register stage with full throughput.

Parameters:
- W, 8, data width of D0, D1, Y.
- FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = channel 0 always wins.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; asserting it clears state immediately; deassertion is synchronised externally.
- D0  input  W  channel 0 data.
- V0  input  1  channel 0 valid.
- R0  output  1  channel 0 ready.
- D1  input  W  channel 1 data.
- V1  input  1  channel 1 valid.
- R1  output  1  channel 1 ready.
- Y  output  W  merged data (registered).
- YV  output  1  Y valid (registered).
- S  output  1  source of current Y beat: 0 = D0, 1 = D1 (registered).
- YR  input  1  downstream ready.

Behaviour:
- Transfer rule:
  - Transfer on any channel occurs in a cycle where valid and ready are both 1 at the rising edge.
  - Upstream must hold Dn stable while Vn=1 and Rn=0. The block does not check this.
- Reset (rst_n=0, async):
  - Y=0, YV=0, S=0, last=1. The first contended grant therefore goes to channel 0.
  - R0=R1=0 while in reset.
  - A beat held in the output register at reset is discarded, not replayed.
- Internal state:
  - Output register {Y, S, YV}.
  - Arbitration pointer last: channel of the most recent accepted beat.
- Space signal: space = ~YV | YR. The register is empty or drains this cycle.
- Grant (combinational, from V0, V1, last):
  - Only V0 -> g0. Only V1 -> g1. Neither -> none.
  - Both, FIXED_PRIO=1 -> g0.
  - Both, FIXED_PRIO=0 -> grant the channel != last.
- Readies:
  - R0 = space & g0; R1 = space & g1.
  - At most one of R0/R1 is 1 in any cycle.
  - A non-granted channel sees R=0 even if space=1.
  - Rn may depend combinationally on V0, V1, YR. No combinational path from Dn to Y.
- Register update on posedge:
  - Accept (Rn & Vn) -> Y<=Dn, S<=n, YV<=1, last<=n.
  - No accept, YV=1 and YR=1 -> YV<=0. Y and S hold their old values.
  - No accept, YV=1 and YR=0 -> everything holds (Y, S, YV stable under backpressure).
- Latency: an input beat accepted at edge k appears on Y/YV from edge k until it is consumed. Input-to-output latency is 1 cycle.
- Throughput: with YR held at 1, one beat per cycle. Simultaneous drain and accept in the same cycle is required and must lose no beat.
- Fairness: in round-robin mode, under continuous V0=V1=1 and YR=1, S alternates 0,1,0,1…
- last changes only on an accepted beat. Idle cycles and backpressure do not move the pointer.
- Ordering: beats from the same channel leave in the order they were accepted. No beat is duplicated or dropped.
- Output states:
  - EMPTY (YV=0): EMPTY -> FULL on accept.
  - FULL (YV=1):
    - FULL -> FULL on accept with YR=1, or on YR=0.
    - FULL -> EMPTY on YR=1 with no accept.

Test Plan:
- Reset, single channel, held data: W=8, reset, release; V0=1, D0=8'hA5, V1=0, YR=1 -> R0=1; next cycle Y=8'hA5, S=0, YV=1. Hold V0=1 with D0=8'hA5 for 3 more cycles -> YV remains 1 with Y=8'hA5, S=0, one new beat per cycle.
- Round-robin contention: FIXED_PRIO=0; V0=V1=1, D0=8'h11, D1=8'h22, YR=1 for 4 cycles -> output sequence (Y,S) = (11,0),(22,1),(11,0),(22,1).
- Fixed priority: FIXED_PRIO=1, same stimulus -> Y=8'h11, S=0 every cycle; R1 stays 0 throughout.
- Backpressure: accept D1=8'h3C, then YR=0 for 3 cycles with V0=1 -> Y=8'h3C, S=1, YV=1 stable and R0=R1=0. YR=1 -> 3C consumed and the D0 beat accepted in the same edge. Next cycle Y=D0, S=0.
- Drain to empty: single beat 8'h7E, then V0=V1=0, YR=1 -> YV falls to 0 one cycle after the beat is consumed. last is unchanged: the next contended grant goes to the channel other than S of 7E.
- Reset mid-operation: YV=1, YR=0 holding 8'h55; pulse rst_n low asynchronously mid-cycle -> YV, Y, S drop to 0 immediately. After release, the first contended grant goes to channel 0 and 8'h55 never appears.
